imm_narrow: RTL and testbench

- Streaming signed narrowing unit: accepts 16-bit signed datapath values and produces 11-bit signed immediate-field values for the instruction encoder / assembler-loader path.
- Inverse of the decode-side 11-to-16 sign extension. Any result that does not overflow, when sign-extended back to 16 bits, equals the input exactly.
- Range check, optional saturation, a 2-entry output buffer with valid/ready handshakes, and overflow statistics.

---
 rtl/imm_narrow_pkg.sv | 17 +
 rtl/imm_narrow_core.sv | 23 ++
 rtl/imm_narrow.sv | 116 +++++++++++
 tb/tb_imm_narrow.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_narrow_pkg.sv
// Shared widths, saturation limits and buffer occupancy states for the
// 16-to-11 bit signed immediate narrowing path.
package imm_narrow_pkg;

  localparam int IN_W_DEF  = 16;
  localparam int OUT_W_DEF = 11;

  localparam logic [OUT_W_DEF-1:0] SAT_MAX = {1'b0, {(OUT_W_DEF-1){1'b1}}};
  localparam logic [OUT_W_DEF-1:0] SAT_MIN = {1'b1, {(OUT_W_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/imm_narrow_core.sv
// Combinational signed range check with optional saturation; wraps by
// truncation when saturation is off.
module narrow_core #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 11
) (
  input  logic [IN_W-1:0]  data,
  input  logic             sat_en,
  output logic [OUT_W-1:0] result,
  output logic             ovf
);

  logic [IN_W-OUT_W:0] upper;
  logic [OUT_W-1:0]    sat_val;

  // Every bit from the output sign position upward must agree.
  assign upper   = data[IN_W-1:OUT_W-1];
  assign ovf     = !((&upper) || !(|upper));
  assign sat_val = data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                : {1'b0, {(OUT_W-1){1'b1}}};
  assign result  = (ovf && sat_en) ? sat_val : data[OUT_W-1:0];

endmodule

// File: rtl/imm_narrow.sv
// Streaming narrowing unit: range check, 2-entry registered output buffer
// with valid/ready handshakes, and overflow statistics.
//
// state | meaning
// EMPTY | no word buffered, out_valid low
// ONE   | head holds one word, tail unused
// FULL  | head and tail both hold words, in_ready low
module imm_narrow
  import imm_narrow_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  input  logic             clr_stats,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  logic [OUT_W-1:0] nar_data;
  logic             nar_ovf;
  logic [OUT_W-1:0] tail_data;
  logic             tail_ovf;
  logic             push;
  logic             pop;
  occ_t             state;

  narrow_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .data   (in_data),
    .sat_en (sat_en),
    .result (nar_data),
    .ovf    (nar_ovf)
  );

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Head register drives out_* directly; tail only fills while head is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      tail_data <= '0;
      tail_ovf  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            out_data  <= nar_data;
            out_ovf   <= nar_ovf;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            out_data <= nar_data;
            out_ovf  <= nar_ovf;
          end else if (push) begin
            tail_data <= nar_data;
            tail_ovf  <= nar_ovf;
            in_ready  <= 1'b0;
            state     <= FULL;
          end else if (pop) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            out_data <= tail_data;
            out_ovf  <= tail_ovf;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= EMPTY;
        end
      endcase
    end
  end

  // A new overflow event in the same cycle as a clear counts as the first event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (push && nar_ovf) begin
      ovf_sticky <= 1'b1;
      if (clr_stats)
        ovf_count <= {{(CNT_W-1){1'b0}}, 1'b1};
      else if (ovf_count != {CNT_W{1'b1}})
        ovf_count <= ovf_count + 1'b1;
    end else if (clr_stats) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end
  end

endmodule

// File: tb/tb_imm_narrow.sv
// Scoreboard bench for imm_narrow: driver queues expected words, monitor
// compares them as the buffer head is popped.
module tb_imm_narrow;
  import imm_narrow_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        sat_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [10:0] out_data;
  logic        out_ovf;
  logic        clr_stats = 1'b0;
  logic        ovf_sticky;
  logic [7:0]  ovf_count;

  typedef struct packed {
    logic [15:0] src;
    logic [10:0] data;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   rand_rdy = 1'b0;

  imm_narrow dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sat_en(sat_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
    .clr_stats(clr_stats), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] d, input logic s);
    exp_t e;
    int   v;
    v = int'($signed(d));
    e.src = d;
    e.ovf = (v > 1023) || (v < -1024);
    if (e.ovf && s) e.data = (v < 0) ? SAT_MIN : SAT_MAX;
    else            e.data = d[10:0];
    return e;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [15:0] d, input logic s);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    sat_en   = s;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(d, s));
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: compare on pop, and check head stability while stalled.
  logic [11:0] held;
  bit          holding = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      holding = 1'b0;
    end else begin
      if (holding && out_valid) chk("head_stable", {out_data, out_ovf}, held);
      holding = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {out_data, out_ovf}, 32'hdead);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_ovf", out_ovf, e.ovf);
          if (!e.ovf) chk("round_trip", {{5{out_data[10]}}, out_data}, e.src);
        end
      end else if (out_valid) begin
        held    = {out_data, out_ovf};
        holding = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = $urandom_range(0, 1) != 0;
    end
  end

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1 chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    logic [15:0] dir_in [4];
    dir_in = '{16'h03FF, 16'hFC00, 16'h0000, 16'hFFFF};

    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_sticky", ovf_sticky, 0);
    chk("rst_count", ovf_count, 0);
    chk("rst_in_ready", in_ready, 1);

    // In-range boundaries, one cycle latency
    out_ready = 1'b1;
    foreach (dir_in[i]) begin
      push(dir_in[i], 1'b1);
      chk("latency_valid", out_valid, 1);
    end
    drain();
    chk("count_inrange", ovf_count, 0);
    chk("sticky_inrange", ovf_sticky, 0);

    push(16'h0400, 1'b1);
    push(16'h8000, 1'b1);
    drain();
    chk("sticky_sat", ovf_sticky, 1);
    chk("count_sat", ovf_count, 2);
    push(16'h0400, 1'b0);
    drain();
    chk("count_wrap", ovf_count, 3);

    // Backpressure: two fill the buffer, third waits
    out_ready = 1'b0;
    push(16'h0011, 1'b1);
    push(16'hFF22, 1'b1);
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    @(posedge clk); #1;
    fork
      push(16'h0133, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Clear alone, then saturate the counter
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    chk("clr_sticky", ovf_sticky, 0);
    chk("clr_count", ovf_count, 0);
    for (int i = 0; i < 254; i++) push(16'h7000 + 16'(i), 1'b1);
    drain();
    chk("count_254", ovf_count, 254);
    for (int i = 0; i < 3; i++) begin
      push(16'h9000, 1'b0);
      chk("count_sat255", ovf_count, 255);
    end
    clr_stats = 1'b1;
    push(16'hF000, 1'b1);
    clr_stats = 1'b0;
    chk("clr_ovf_count", ovf_count, 1);
    chk("clr_ovf_sticky", ovf_sticky, 1);
    drain();

    // Random stream with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [15:0] r;
      r = (i % 2 == 0) ? 16'($urandom_range(0, 2047) - 1024) : 16'($urandom);
      push(r, $urandom_range(0, 1) != 0);
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    // Reset with words buffered
    out_ready = 1'b0;
    push(16'h0005, 1'b1);
    push(16'h4000, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sticky", ovf_sticky, 0);
    chk("midrst_count", ovf_count, 0);
    chk("midrst_in_ready", in_ready, 1);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("post_rst_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
